wb_rr_arbiter: RTL

WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

---
 rtl/wb_rr_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/wb_rr_arbiter.sv
// rtl/wb_rr_arbiter.sv - round-robin Wishbone arbiter, N masters onto one slave
// Optional response watchdog enabled by defining WB_ARB_WATCHDOG_EN.
module wb_rr_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int DW          = 32,
  parameter int AW          = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NUM_MASTERS*AW-1:0]  wbm_adr_i,
  input  logic [NUM_MASTERS*DW-1:0]  wbm_dat_i,
  input  logic [NUM_MASTERS*DW/8-1:0] wbm_sel_i,
  input  logic [NUM_MASTERS-1:0]     wbm_we_i,
  input  logic [NUM_MASTERS-1:0]     wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]     wbm_stb_i,
  input  logic [3*NUM_MASTERS-1:0]   wbm_cti_i,
  input  logic [2*NUM_MASTERS-1:0]   wbm_bte_i,
  output logic [NUM_MASTERS*DW-1:0]  wbm_dat_o,
  output logic [NUM_MASTERS-1:0]     wbm_ack_o,
  output logic [NUM_MASTERS-1:0]     wbm_err_o,
  output logic [NUM_MASTERS-1:0]     wbm_rty_o,
  output logic [AW-1:0]              wbs_adr_o,
  output logic [DW-1:0]              wbs_dat_o,
  output logic [DW/8-1:0]            wbs_sel_o,
  output logic                       wbs_we_o,
  output logic                       wbs_cyc_o,
  output logic                       wbs_stb_o,
  output logic [2:0]                 wbs_cti_o,
  output logic [1:0]                 wbs_bte_o,
  input  logic [DW-1:0]              wbs_dat_i,
  input  logic                       wbs_ack_i,
  input  logic                       wbs_err_i,
  input  logic                       wbs_rty_i,
  output logic [NUM_MASTERS-1:0]     grant_o
);

  localparam int LW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int SW = DW / 8;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t                 r_state, w_state_nxt;
  logic [NUM_MASTERS-1:0] r_grant, w_grant_nxt;
  logic [LW-1:0]          r_idx, w_idx_nxt;
  logic [LW-1:0]          r_last, w_last_nxt;
  logic [LW-1:0]          w_pick, w_cand, w_sel;
  logic                   w_found;
  logic                   w_busy;
  logic                   w_timeout;
  int                     w_c;

  // Scan starts just past the last owner so every waiting master gets a turn.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_last;
    w_cand  = r_last;
    w_c     = 0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      w_c = int'(r_last) + i;
      if (w_c >= NUM_MASTERS) w_c = w_c - NUM_MASTERS;
      w_cand = LW'(w_c);
      if (!w_found && wbm_cyc_i[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_idx_nxt   = r_idx;
    w_last_nxt  = r_last;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant_nxt         = '0;
          w_grant_nxt[w_pick] = 1'b1;
          w_idx_nxt           = w_pick;
          w_state_nxt         = S_BUSY;
        end
      end
      S_BUSY: begin
        if (!wbm_cyc_i[r_idx]) begin
          w_grant_nxt = '0;
          w_last_nxt  = r_idx;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_idx   <= '0;
      r_last  <= LW'(NUM_MASTERS - 1);
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_idx   <= w_idx_nxt;
      r_last  <= w_last_nxt;
    end
  end

`ifdef WB_ARB_WATCHDOG_EN
  logic [15:0] r_wd;
  logic        w_resp;

  assign w_resp    = wbs_ack_i | wbs_err_i | wbs_rty_i;
  assign w_timeout = w_busy && (r_wd == 16'(TIMEOUT));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wd <= '0;
    end else if (!w_busy || w_resp || w_timeout) begin
      r_wd <= '0;
    end else if (|(r_grant & wbm_stb_i)) begin
      r_wd <= r_wd + 16'd1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Idle steers master 0 onto the data/address path; control stays low.
  assign w_busy    = (r_state == S_BUSY);
  assign w_sel     = w_busy ? r_idx : '0;

  assign wbs_adr_o = wbm_adr_i[int'(w_sel)*AW +: AW];
  assign wbs_dat_o = wbm_dat_i[int'(w_sel)*DW +: DW];
  assign wbs_sel_o = wbm_sel_i[int'(w_sel)*SW +: SW];
  assign wbs_cti_o = wbm_cti_i[int'(w_sel)*3 +: 3];
  assign wbs_bte_o = wbm_bte_i[int'(w_sel)*2 +: 2];
  assign wbs_we_o  = w_busy & wbm_we_i[w_sel];
  assign wbs_cyc_o = |(r_grant & wbm_cyc_i);
  assign wbs_stb_o = |(r_grant & wbm_stb_i) & ~w_timeout;

  assign wbm_dat_o = {NUM_MASTERS{wbs_dat_i}};
  assign wbm_ack_o = r_grant & {NUM_MASTERS{wbs_ack_i}};
  assign wbm_err_o = r_grant & {NUM_MASTERS{wbs_err_i | w_timeout}};
  assign wbm_rty_o = r_grant & {NUM_MASTERS{wbs_rty_i}};
  assign grant_o   = r_grant;

endmodule
